// File: rtl/awg_playback_reader.sv
// Waveform playback reader: walks a BRAM region for a number of loops and streams
// samples out over valid/ready through a 2-entry buffer with a read-data bypass.
module awg_playback_reader #(
  parameter int unsigned P_ADDR_WIDTH = 8,
  parameter int unsigned P_DATA_WIDTH = 32,
  parameter int unsigned P_LOOP_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic [P_ADDR_WIDTH-1:0]   cfg_base_addr,
  input  logic [P_ADDR_WIDTH:0]     cfg_length,
  input  logic [P_LOOP_WIDTH-1:0]   cfg_loops,
  output logic [P_ADDR_WIDTH-1:0]   mem_addr,
  input  logic [P_DATA_WIDTH-1:0]   mem_rdata,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [P_DATA_WIDTH-1:0]   m_data,
  output logic                      m_last,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int unsigned LW = P_ADDR_WIDTH + 1;
  localparam logic [LW-1:0] MAX_LEN = LW'(1) << P_ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                    r_state, w_state_nxt;
  logic [P_ADDR_WIDTH-1:0]   r_base, r_offset, r_mem_addr;
  logic [LW-1:0]             r_len;
  logic [P_LOOP_WIDTH-1:0]   r_loops;
  logic                      r_iss, r_iss_last, r_dv, r_dv_last;
  logic [P_DATA_WIDTH-1:0]   r_fifo_data [2];
  logic                      r_fifo_last [2];
  logic                      r_rd_ptr, r_wr_ptr;
  logic [1:0]                r_count;
  logic                      r_done, r_err;

  logic                      w_idle_start, w_len_ok, w_launch, w_pop, w_room, w_issue;
  logic                      w_push, w_fpop, w_last_of_loop, w_final;
  logic [2:0]                w_occ;
  logic [P_ADDR_WIDTH-1:0]   w_cur_base, w_cur_off;
  logic [LW-1:0]             w_cur_len;
  logic [P_LOOP_WIDTH-1:0]   w_cur_loops;

  // Output side: buffer head first, otherwise the read data arriving this cycle
  assign m_valid  = (r_count != 2'd0) || r_dv;
  assign m_data   = (r_count != 2'd0) ? r_fifo_data[r_rd_ptr] : (r_dv ? mem_rdata : '0);
  assign m_last   = (r_count != 2'd0) ? r_fifo_last[r_rd_ptr] : (r_dv && r_dv_last);
  assign mem_addr = r_mem_addr;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign err      = r_err;

  assign w_pop        = m_valid && m_ready;
  assign w_idle_start = (r_state == S_IDLE) && start && !stop;
  assign w_len_ok     = (cfg_length != '0) && (cfg_length <= MAX_LEN);
  assign w_launch     = w_idle_start && w_len_ok;

  // Occupancy counts buffered entries plus both read pipeline stages
  assign w_occ   = 3'(r_count) + 3'(r_iss) + 3'(r_dv) - 3'(w_pop);
  assign w_room  = (w_occ < 3'd2);
  assign w_issue = w_launch || ((r_state == S_RUN) && !stop && w_room);

  // The launch cycle issues offset 0 straight from the config inputs
  assign w_cur_base  = (r_state == S_IDLE) ? cfg_base_addr : r_base;
  assign w_cur_len   = (r_state == S_IDLE) ? cfg_length    : r_len;
  assign w_cur_loops = (r_state == S_IDLE) ? cfg_loops     : r_loops;
  assign w_cur_off   = (r_state == S_IDLE) ? '0            : r_offset;

  assign w_last_of_loop = (LW'(w_cur_off) == (w_cur_len - LW'(1)));
  assign w_final        = w_last_of_loop && (w_cur_loops == P_LOOP_WIDTH'(1));

  assign w_push = r_dv && !(w_pop && (r_count == 2'd0));
  assign w_fpop = w_pop && (r_count != 2'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_launch) w_state_nxt = w_final ? S_DRAIN : S_RUN;
      S_RUN: begin
        if (stop)                    w_state_nxt = S_IDLE;
        else if (w_issue && w_final) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (stop)                 w_state_nxt = S_IDLE;
        else if (w_pop && m_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_base     <= '0;
      r_len      <= '0;
      r_loops    <= '0;
      r_offset   <= '0;
      r_mem_addr <= '0;
      r_iss      <= 1'b0;
      r_iss_last <= 1'b0;
      r_dv       <= 1'b0;
      r_dv_last  <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_last[i] <= 1'b0;
      end
    end else begin
      r_done <= (r_state == S_DRAIN) && !stop && w_pop && m_last;
      r_err  <= w_idle_start && !w_len_ok;
      if (w_launch) begin
        r_base <= cfg_base_addr;
        r_len  <= cfg_length;
      end
      if (w_issue) begin
        r_mem_addr <= w_cur_base + w_cur_off;
        r_offset   <= w_last_of_loop ? '0 : (w_cur_off + P_ADDR_WIDTH'(1));
        r_loops    <= (w_last_of_loop && (w_cur_loops != '0)) ?
                      (w_cur_loops - P_LOOP_WIDTH'(1)) : w_cur_loops;
      end
      if (stop) begin
        // Abort drops buffered and in-flight samples alike
        r_iss    <= 1'b0;
        r_dv     <= 1'b0;
        r_count  <= 2'd0;
        r_rd_ptr <= 1'b0;
        r_wr_ptr <= 1'b0;
      end else begin
        r_iss      <= w_issue;
        r_iss_last <= w_final;
        r_dv       <= r_iss;
        r_dv_last  <= r_iss_last;
        if (w_push) begin
          r_fifo_data[r_wr_ptr] <= mem_rdata;
          r_fifo_last[r_wr_ptr] <= r_dv_last;
          r_wr_ptr              <= ~r_wr_ptr;
        end
        if (w_fpop) r_rd_ptr <= ~r_rd_ptr;
        r_count <= r_count + 2'(w_push) - 2'(w_fpop);
      end
    end
  end

endmodule

// File: tb/tb_awg_playback_reader.sv
// Directed bench for awg_playback_reader with a latency-1 BRAM model whose
// contents are a fixed function of the address.
module tb_awg_playback_reader;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, m_ready;
  logic [7:0]  cfg_base_addr;
  logic [8:0]  cfg_length;
  logic [15:0] cfg_loops;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic        m_valid, m_last, busy, done, err;
  logic [31:0] m_data;

  int n_tests = 0;
  int n_fail  = 0;

  awg_playback_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_base_addr(cfg_base_addr), .cfg_length(cfg_length), .cfg_loops(cfg_loops),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [7:0] a);
    return {8'hC3, a, ~a, a ^ 8'h5A};
  endfunction

  always @(posedge clk) mem_rdata <= mem_fn(mem_addr);

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; m_ready = 1'b1;
    cfg_base_addr = '0; cfg_length = 9'd1; cfg_loops = 16'd1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({m_valid, m_last, busy, done, err} !== 5'b0 || mem_addr !== 8'h00 || m_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: v=%b l=%b b=%b d=%b e=%b addr=%h data=%h, want all zero",
               m_valid, m_last, busy, done, err, mem_addr, m_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Full playback with m_ready held high: one sample per cycle from cycle 2
  task automatic test_continuous(input string name, input logic [7:0] base, input int len, input int loops);
    int total;
    logic [7:0] ea;
    total = len * loops;
    @(negedge clk);
    cfg_base_addr = base; cfg_length = 9'(len); cfg_loops = 16'(loops);
    m_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (mem_addr !== base || busy !== 1'b1 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_cycle1: addr=%h busy=%b valid=%b, want addr=%h busy=1 valid=0",
               name, mem_addr, busy, m_valid, base);
    end
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      ea = base + 8'(i % len);
      n_tests++;
      if (m_valid !== 1'b1 || m_data !== mem_fn(ea) || m_last !== (i == total - 1)) begin
        n_fail++;
        $display("FAIL %s_sample%0d: valid=%b data=%h last=%b, want valid=1 data=%h last=%b",
                 name, i, m_valid, m_data, m_last, mem_fn(ea), (i == total - 1));
      end
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done: done=%b busy=%b valid=%b, want 1 0 0", name, done, busy, m_valid);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_pulse: done=%b, want 0", name, done);
    end
  endtask

  task automatic test_stall();
    logic [0:19] pat;
    logic        prev_stall, saw_done;
    logic [31:0] prev_data;
    logic        prev_last;
    int          k;
    pat = 20'b1001_0110_0101_1010_1111;
    k = 0; prev_stall = 1'b0; saw_done = 1'b0; prev_data = '0; prev_last = 1'b0;
    @(negedge clk);
    cfg_base_addr = 8'h60; cfg_length = 9'd3; cfg_loops = 16'd1; start = 1'b1;
    m_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      m_ready = pat[c % 20];
      #1;
      if (done === 1'b1) saw_done = 1'b1;
      if (prev_stall) begin
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
          n_fail++;
          $display("FAIL stall_hold_c%0d: valid=%b data=%h last=%b, want 1 %h %b",
                   c, m_valid, m_data, m_last, prev_data, prev_last);
        end
      end
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        n_tests++;
        if (k > 2 || m_data !== mem_fn(8'h60 + 8'(k)) || m_last !== (k == 2)) begin
          n_fail++;
          $display("FAIL stall_sample%0d: data=%h last=%b, want data=%h last=%b",
                   k, m_data, m_last, mem_fn(8'h60 + 8'(k)), (k == 2));
        end
        k++;
      end
      prev_stall = (m_valid === 1'b1) && (m_ready === 1'b0);
      prev_data  = m_data;
      prev_last  = m_last;
    end
    n_tests++;
    if (k != 3 || !saw_done) begin
      n_fail++;
      $display("FAIL stall_count: samples=%0d done_seen=%b, want 3 and 1", k, saw_done);
    end
    m_ready = 1'b1;
  endtask

  task automatic test_forever_stop();
    logic bad_done;
    @(negedge clk);
    cfg_base_addr = 8'h40; cfg_length = 9'd2; cfg_loops = 16'd0; start = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (m_valid !== 1'b1 || m_data !== mem_fn(8'h40 + 8'(i % 2)) || m_last !== 1'b0) begin
        n_fail++;
        $display("FAIL forever_sample%0d: valid=%b data=%h last=%b, want 1 %h 0",
                 i, m_valid, m_data, m_last, mem_fn(8'h40 + 8'(i % 2)));
      end
    end
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_tests++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_effect: valid=%b busy=%b done=%b, want 0 0 0", m_valid, busy, done);
    end
    bad_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || m_valid !== 1'b0) bad_done = 1'b1;
    end
    n_tests++;
    if (bad_done) begin
      n_fail++;
      $display("FAIL stop_no_done: stray done/valid after stop=%b, want 0", bad_done);
    end
    test_continuous("restart", 8'h40, 2, 1);
  endtask

  task automatic test_err_and_busy_start();
    int   k;
    logic saw_done;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      cfg_length = (t == 0) ? 9'd0 : 9'd257; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_tests++;
      if (err !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL err_pulse_len%0d: err=%b busy=%b, want 1 0", cfg_length, err, busy);
      end
      @(negedge clk);
      n_tests++;
      if (err !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL err_clear_len%0d: err=%b busy=%b, want 0 0", cfg_length, err, busy);
      end
    end
    @(negedge clk);
    cfg_base_addr = 8'h20; cfg_length = 9'd2; cfg_loops = 16'd1; start = 1'b1; m_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    cfg_base_addr = 8'h80; cfg_length = 9'd5; cfg_loops = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (err !== 1'b0 || busy !== 1'b1 || m_valid !== 1'b1 || m_data !== mem_fn(8'h20)) begin
      n_fail++;
      $display("FAIL busy_start_hold: err=%b busy=%b valid=%b data=%h, want 0 1 1 %h",
               err, busy, m_valid, m_data, mem_fn(8'h20));
    end
    m_ready = 1'b1;
    k = 0; saw_done = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (done === 1'b1) saw_done = 1'b1;
      if (m_valid === 1'b1) begin
        n_tests++;
        if (k > 1 || m_data !== mem_fn(8'h20 + 8'(k)) || m_last !== (k == 1)) begin
          n_fail++;
          $display("FAIL busy_start_sample%0d: data=%h last=%b, want %h %b",
                   k, m_data, m_last, mem_fn(8'h20 + 8'(k)), (k == 1));
        end
        k++;
      end
    end
    n_tests++;
    if (k != 2 || !saw_done || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_count: samples=%0d done_seen=%b busy=%b, want 2 1 0", k, saw_done, busy);
    end
  endtask

  task automatic test_reset_drain();
    @(negedge clk);
    cfg_base_addr = 8'h30; cfg_length = 9'd2; cfg_loops = 16'd1; start = 1'b1; m_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || m_valid !== 1'b1 || m_data !== mem_fn(8'h30)) begin
      n_fail++;
      $display("FAIL drain_pre: busy=%b valid=%b data=%h, want 1 1 %h", busy, m_valid, m_data, mem_fn(8'h30));
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({m_valid, m_last, busy, done, err} !== 5'b0 || mem_addr !== 8'h00 || m_data !== 32'h0) begin
      n_fail++;
      $display("FAIL drain_reset: v=%b l=%b b=%b d=%b e=%b addr=%h data=%h, want all zero",
               m_valid, m_last, busy, done, err, mem_addr, m_data);
    end
    rst_n = 1'b1;
    cfg_base_addr = 8'h33; cfg_length = 9'd1; cfg_loops = 16'd1; start = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b1 || mem_addr !== 8'h33) begin
      n_fail++;
      $display("FAIL post_reset_start: done=%b busy=%b addr=%h, want 0 1 33", done, busy, mem_addr);
    end
    @(negedge clk);
    n_tests++;
    if (m_valid !== 1'b1 || m_data !== mem_fn(8'h33) || m_last !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_sample: valid=%b data=%h last=%b, want 1 %h 1",
               m_valid, m_data, m_last, mem_fn(8'h33));
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_done: done=%b, want 1", done);
    end
  endtask

  initial begin
    test_reset();
    test_continuous("basic", 8'h10, 4, 2);
    test_continuous("wrap", 8'hFE, 4, 1);
    test_continuous("len1", 8'h05, 1, 3);
    test_stall();
    test_forever_stop();
    test_err_and_busy_start();
    test_reset_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/awg_playback_reader.md
AWG_PLAYBACK_READER -- requirements
Module: awg_playback_reader

Interface
REQ-001 SHALL have parameter P_ADDR_WIDTH, default 8, waveform memory address width.
REQ-002 SHALL have parameter P_DATA_WIDTH, default 32, sample width.
REQ-003 SHALL have parameter P_LOOP_WIDTH, default 16, loop counter width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  one-cycle playback request.
REQ-007 stop  input  1  one-cycle abort request.
REQ-008 cfg_base_addr  input  P_ADDR_WIDTH  first sample address.
REQ-009 cfg_length  input  P_ADDR_WIDTH+1  samples per loop, legal 1..2^P_ADDR_WIDTH.
REQ-010 cfg_loops  input  P_LOOP_WIDTH  loop count; 0 = play forever until stop.
REQ-011 mem_addr  output  P_ADDR_WIDTH  read address to BRAM read port (port enable tied high, fixed read latency 1).
REQ-012 mem_rdata  input  P_DATA_WIDTH  BRAM read data, valid one cycle after mem_addr.
REQ-013 m_valid / m_ready / m_data (P_DATA_WIDTH)  out / in / out  sample stream, valid-ready handshake.
REQ-014 m_last  output  1  marks final sample of final loop (never set when cfg_loops=0).
REQ-015 busy  output  1  high in RUN or DRAIN; done  output  1  one-cycle completion pulse; err  output  1  one-cycle illegal-config pulse.

Function
REQ-016 States SHALL be IDLE, RUN (issuing reads), DRAIN (all reads issued, buffer not empty).
REQ-017 In IDLE, start with legal cfg_length SHALL latch cfg_* and enter RUN next cycle; start with cfg_length=0 or >2^P_ADDR_WIDTH SHALL pulse err next cycle and remain IDLE.
REQ-018 start while busy SHALL be ignored; cfg_* changes while busy SHALL have no effect.
REQ-019 A 2-entry output FIFO SHALL hold read data; a read SHALL be issued in a cycle only if (fifo_count + reads_in_flight - pop_this_cycle) < 2, guaranteeing no overflow.
REQ-020 Read address SHALL be (base + offset) mod 2^P_ADDR_WIDTH; offset SHALL step 0..cfg_length-1 then wrap to 0 and decrement remaining loops.
REQ-021 Timing: start sampled at edge 0 -> mem_addr=base during cycle 1 -> m_valid=1 with sample[base] in cycle 2; with m_ready held high, one sample per cycle, no bubbles, including across loop wraps.
REQ-022 m_data and m_last SHALL remain stable while m_valid=1 and m_ready=0; m_valid SHALL not drop without a handshake except on stop/reset.
REQ-023 After the last read of the last loop RUN SHALL go to DRAIN; DRAIN SHALL go to IDLE on the handshake of the m_last sample, with done=1 in the following cycle.
REQ-024 cfg_loops=0 SHALL never leave RUN except via stop.
REQ-025 stop (any busy state) SHALL cease reads, flush FIFO and in-flight data, drive m_valid=0 and enter IDLE next cycle; no done pulse; stop has priority over a coincident final handshake.
REQ-026 start and stop in the same IDLE cycle: stop wins, no playback starts.
REQ-027 mem_addr SHALL hold its last value when no read is issued.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE, flush FIFO, clear counters; outputs m_valid=0, m_last=0, busy=0, done=0, err=0, mem_addr=0, m_data=0.
REQ-029 Reset mid-playback SHALL behave as REQ-028 with no done pulse; first cycle after release SHALL accept start.

Verification
REQ-030 base=0x10, length=4, loops=2, m_ready=1 -> m_data from addresses 10,11,12,13,10,11,12,13 on consecutive cycles 2..9, m_last at cycle 9, done at cycle 10.
REQ-031 base=0xFE, length=4, loops=1 (AW=8) -> addresses FE,FF,00,01; m_last on 01.
REQ-032 length=3, loops=1, m_ready toggling 1,0,0,1,0,1... -> exact 3 samples in order, data stable during stalls, no loss or duplicate.
REQ-033 loops=0, length=2, stop asserted after 5 handshakes -> m_valid=0 next cycle, busy=0, no done; new start then plays from base.
REQ-034 start with cfg_length=0 -> err pulse one cycle, busy stays 0; start during busy -> ignored.
REQ-035 rst_n=0 during DRAIN with m_ready=0 -> all outputs at reset values next cycle, no done.
